// File: rtl/fnn_pkg.sv
// Shared types and helpers for the fully connected layer sequencer.
package fnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        WAIT,
        DRAIN
    } fnn_state_e;

    localparam int CFG_W = 32;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fnn_vec_buf.sv
// Input vector register file: one write port, one registered read port.
module fnn_vec_buf
    import fnn_pkg::*;
#(
    parameter int DEPTH = 30,
    parameter int WIDTH = 16,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Write-through keeps a single-element vector readable in the cycle it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdData_q <= '0;
        end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rdData_q <= wr_data_i;
        end else begin
            rdData_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/fnn_layer_ctrl.sv
// Per-layer sequencer: forwards neuron configuration, bursts the buffered
// input vector to the neurons, collects activations and streams them out.
module fnn_layer_ctrl
    import fnn_pkg::*;
#(
    parameter int LAYER_NO     = 2,
    parameter int NUM_NEURON   = 30,
    parameter int NUM_INPUT    = 30,
    parameter int DATA_WIDTH   = 16,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic                             cfg_is_bias,
    input  logic [CFG_W-1:0]                 cfg_neuron,
    input  logic [CFG_W-1:0]                 cfg_data,
    output logic                             weightValid,
    output logic                             biasValid,
    output logic [CFG_W-1:0]                 weightValue,
    output logic [CFG_W-1:0]                 biasValue,
    output logic [CFG_W-1:0]                 config_layer_num,
    output logic [CFG_W-1:0]                 config_neuron_num,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic [DATA_WIDTH-1:0]            neuron_in,
    output logic                             neuron_in_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURON-1:0]            neuron_outvalid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int IN_W  = idx_w(NUM_INPUT);
    localparam int NEU_W = idx_w(NUM_NEURON);
    localparam int TMO_W = idx_w(WAIT_TIMEOUT);

    localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(NUM_INPUT - 1);
    localparam logic [NEU_W-1:0] LAST_NEU = NEU_W'(NUM_NEURON - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(WAIT_TIMEOUT - 1);

    fnn_state_e state_q, state_d;
    logic [IN_W-1:0]       inIdx_q, inIdx_d;
    logic [TMO_W-1:0]      waitCnt_q, waitCnt_d;
    logic [NEU_W-1:0]      outIdx_q, outIdx_d;
    logic [NUM_NEURON-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] res_q [NUM_NEURON];
    logic [DATA_WIDTH-1:0] res_d [NUM_NEURON];
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  weightValid_q, biasValid_q;
    logic [CFG_W-1:0]      weightValue_q, biasValue_q, layerNum_q, neuronNum_q;

    logic                  cfgAccept, cfgInRange;
    logic                  bufWrEn;
    logic [IN_W-1:0]       bufRdAddr;
    logic [DATA_WIDTH-1:0] bufRdData;

    // Start takes priority over a simultaneous configuration write.
    assign cfg_ready  = (state_q == IDLE) && !start;
    assign cfgAccept  = cfg_ready && cfg_valid;
    assign cfgInRange = (cfg_neuron < CFG_W'(NUM_NEURON));

    fnn_vec_buf #(
        .DEPTH(NUM_INPUT),
        .WIDTH(DATA_WIDTH)
    ) u_vec_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (bufWrEn),
        .wr_addr_i(inIdx_q),
        .wr_data_i(in_data),
        .rd_addr_i(bufRdAddr),
        .rd_data_o(bufRdData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            inIdx_q   <= '0;
            waitCnt_q <= '0;
            outIdx_q  <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_NEURON; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            inIdx_q   <= inIdx_d;
            waitCnt_q <= waitCnt_d;
            outIdx_q  <= outIdx_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            done_q    <= done_d;
            res_q     <= res_d;
        end
    end

    // The read address runs one element ahead so the registered read port
    // delivers a gap-free burst starting the cycle FEED is entered.
    always_comb begin
        state_d   = state_q;
        inIdx_d   = inIdx_q;
        waitCnt_d = waitCnt_q;
        outIdx_d  = outIdx_q;
        mask_d    = mask_q;
        res_d     = res_q;
        err_d     = err_q;
        done_d    = 1'b0;
        bufWrEn   = 1'b0;
        bufRdAddr = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    inIdx_d = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    bufWrEn = 1'b1;
                    if (inIdx_q == LAST_IN) begin
                        state_d = FEED;
                        inIdx_d = '0;
                        mask_d  = '0;
                        for (int i = 0; i < NUM_NEURON; i++) begin
                            res_d[i] = '0;
                        end
                    end else begin
                        inIdx_d = inIdx_q + 1'b1;
                    end
                end
            end
            FEED: begin
                if (inIdx_q == LAST_IN) begin
                    state_d   = WAIT;
                    inIdx_d   = '0;
                    waitCnt_d = '0;
                end else begin
                    inIdx_d   = inIdx_q + 1'b1;
                    bufRdAddr = inIdx_q + 1'b1;
                end
            end
            WAIT: begin
                for (int i = 0; i < NUM_NEURON; i++) begin
                    if (neuron_outvalid[i]) begin
                        mask_d[i] = 1'b1;
                        res_d[i]  = neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (&mask_d) begin
                    state_d  = DRAIN;
                    outIdx_d = '0;
                end else if (waitCnt_q == LAST_TMO) begin
                    state_d  = DRAIN;
                    outIdx_d = '0;
                    err_d    = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (outIdx_q == LAST_NEU) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        outIdx_d = outIdx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cfgAccept && !cfgInRange) begin
            err_d = 1'b1;
        end
    end

    // Out-of-range writes are still accepted and latched, but never strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            weightValid_q <= 1'b0;
            biasValid_q   <= 1'b0;
            weightValue_q <= '0;
            biasValue_q   <= '0;
            layerNum_q    <= '0;
            neuronNum_q   <= '0;
        end else begin
            weightValid_q <= cfgAccept && !cfg_is_bias && cfgInRange;
            biasValid_q   <= cfgAccept && cfg_is_bias && cfgInRange;
            if (cfgAccept) begin
                if (cfg_is_bias) begin
                    biasValue_q <= cfg_data;
                end else begin
                    weightValue_q <= cfg_data;
                end
                layerNum_q  <= CFG_W'(LAYER_NO);
                neuronNum_q <= cfg_neuron;
            end
        end
    end

    assign weightValid       = weightValid_q;
    assign biasValid         = biasValid_q;
    assign weightValue       = weightValue_q;
    assign biasValue         = biasValue_q;
    assign config_layer_num  = layerNum_q;
    assign config_neuron_num = neuronNum_q;

    assign in_ready        = (state_q == LOAD);
    assign neuron_in_valid = (state_q == FEED);
    assign neuron_in       = (state_q == FEED) ? bufRdData : '0;
    assign out_valid       = (state_q == DRAIN);
    assign out_data        = (state_q == DRAIN) ? res_q[outIdx_q] : '0;
    assign out_last        = (state_q == DRAIN) && (outIdx_q == LAST_NEU);
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_fnn_layer_ctrl.sv
// Directed bench for fnn_layer_ctrl with a 4-input, 3-neuron, 16-cycle-timeout layer.
module tb_fnn_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_is_bias = 1'b0;
    logic [31:0] cfg_neuron = '0;
    logic [31:0] cfg_data = '0;
    logic        weightValid, biasValid;
    logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [15:0] neuron_in;
    logic        neuron_in_valid;
    logic [47:0] neuron_out = '0;
    logic [2:0]  neuron_outvalid = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last, busy, done, err;

    int testsRun  = 0;
    int failCount = 0;
    int waitCycles;

    always #5 clk = ~clk;

    fnn_layer_ctrl #(
        .LAYER_NO    (2),
        .NUM_NEURON  (3),
        .NUM_INPUT   (4),
        .DATA_WIDTH  (16),
        .WAIT_TIMEOUT(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_is_bias      (cfg_is_bias),
        .cfg_neuron       (cfg_neuron),
        .cfg_data         (cfg_data),
        .weightValid      (weightValid),
        .biasValid        (biasValid),
        .weightValue      (weightValue),
        .biasValue        (biasValue),
        .config_layer_num (config_layer_num),
        .config_neuron_num(config_neuron_num),
        .start            (start),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .neuron_in        (neuron_in),
        .neuron_in_valid  (neuron_in_valid),
        .neuron_out       (neuron_out),
        .neuron_outvalid  (neuron_outvalid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // Advance one cycle, then drive this cycle's inputs and let outputs settle.
    task automatic applyStimulus(input logic s, input logic cv, input logic cb,
                                 input logic [31:0] cn, input logic [31:0] cd,
                                 input logic iv, input logic [15:0] id);
        @(posedge clk);
        #1;
        start       = s;
        cfg_valid   = cv;
        cfg_is_bias = cb;
        cfg_neuron  = cn;
        cfg_data    = cd;
        in_valid    = iv;
        in_data     = id;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        idleCycle();
        checkOutput("rst_cfg_ready", cfg_ready, 1);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_weightValid", weightValid, 0);
        checkOutput("rst_biasValid", biasValid, 0);
        checkOutput("rst_nin_valid", neuron_in_valid, 0);
        checkOutput("rst_neuron_in", neuron_in, 0);
        checkOutput("rst_weightValue", weightValue, 0);
        checkOutput("rst_layer_num", config_layer_num, 0);
        checkOutput("rst_neuron_num", config_neuron_num, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst = 1'b0;

        // Back-to-back configuration writes
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd1, 32'h0000_00AB, 1'b0, 16'd0);
        checkOutput("cfg_ready_idle", cfg_ready, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd2, 32'h0000_FFC0, 1'b0, 16'd0);
        checkOutput("cfg_w_strobe", weightValid, 1);
        checkOutput("cfg_w_nobias", biasValid, 0);
        checkOutput("cfg_w_neuron", config_neuron_num, 1);
        checkOutput("cfg_w_value", weightValue, 32'h0000_00AB);
        checkOutput("cfg_w_layer", config_layer_num, 2);
        idleCycle();
        checkOutput("cfg_b_strobe", biasValid, 1);
        checkOutput("cfg_b_noweight", weightValid, 0);
        checkOutput("cfg_b_neuron", config_neuron_num, 2);
        checkOutput("cfg_b_value", biasValue, 32'h0000_FFC0);
        checkOutput("cfg_err_clear", err, 0);
        idleCycle();
        checkOutput("cfg_b_oneshot", biasValid, 0);

        // Out-of-range neuron index
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd3, 32'h0000_1234, 1'b0, 16'd0);
        idleCycle();
        checkOutput("bad_no_wstrobe", weightValid, 0);
        checkOutput("bad_no_bstrobe", biasValid, 0);
        checkOutput("bad_err_set", err, 1);
        idleCycle();
        checkOutput("bad_err_sticky", err, 1);
        rst = 1'b1;
        idleCycle();
        checkOutput("bad_err_rst", err, 0);
        rst = 1'b0;

        // Pass 1: stalled load, out-of-order capture, stalled drain
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0);
        checkOutput("p1_start_blocks_cfg", cfg_ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h0001);
        checkOutput("p1_in_ready", in_ready, 1);
        checkOutput("p1_busy", busy, 1);
        checkOutput("p1_load_cfg_ready", cfg_ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'h00EE);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h0002);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h0003);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'h00EE);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h0004);
        checkOutput("p1_last_beat_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            checkOutput("p1_feed_valid", neuron_in_valid, 1);
            checkOutput("p1_feed_data", neuron_in, 32'(k + 1));
            checkOutput("p1_feed_in_ready", in_ready, 0);
            if (k == 1) begin
                neuron_out      = {16'h7777, 16'h7777, 16'h7777};
                neuron_outvalid = 3'b111;
            end else begin
                neuron_outvalid = 3'b000;
            end
        end
        idleCycle();
        checkOutput("p1_feed_end", neuron_in_valid, 0);
        checkOutput("p1_wait_no_out", out_valid, 0);
        neuron_out      = {16'h0030, 16'hDEAD, 16'hBEEF};
        neuron_outvalid = 3'b100;
        idleCycle();
        checkOutput("p1_partial_no_out", out_valid, 0);
        neuron_out      = {16'h5555, 16'h5555, 16'h5555};
        neuron_outvalid = 3'b000;
        idleCycle();
        checkOutput("p1_still_waiting", out_valid, 0);
        neuron_out      = {16'h9999, 16'h0020, 16'h0010};
        neuron_outvalid = 3'b011;
        idleCycle();
        neuron_outvalid = 3'b000;
        checkOutput("p1_out_valid", out_valid, 1);
        checkOutput("p1_beat0_data", out_data, 16'h0010);
        checkOutput("p1_beat0_last", out_last, 0);
        idleCycle();
        checkOutput("p1_stall_valid", out_valid, 1);
        checkOutput("p1_stall_data", out_data, 16'h0010);
        idleCycle();
        checkOutput("p1_stall2_data", out_data, 16'h0010);
        out_ready = 1'b1;
        idleCycle();
        checkOutput("p1_beat1_data", out_data, 16'h0020);
        checkOutput("p1_beat1_last", out_last, 0);
        idleCycle();
        checkOutput("p1_beat2_data", out_data, 16'h0030);
        checkOutput("p1_beat2_last", out_last, 1);
        checkOutput("p1_beat2_nodone", done, 0);

        // Start accepted in the done cycle; this pass times out on neuron 1
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0);
        out_ready = 1'b0;
        checkOutput("p1_done", done, 1);
        checkOutput("p1_idle_busy", busy, 0);
        checkOutput("p1_idle_out_valid", out_valid, 0);
        checkOutput("p1_err_clear", err, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h000A);
        checkOutput("p2_done_oneshot", done, 0);
        checkOutput("p2_in_ready", in_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h000B);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h000C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'h000D);
        for (int k = 0; k < 4; k++) begin
            idleCycle();
            checkOutput("p2_feed_valid", neuron_in_valid, 1);
            checkOutput("p2_feed_data", neuron_in, 32'(16'h000A + k));
        end
        idleCycle();
        checkOutput("p2_wait_err0", err, 0);
        neuron_out      = {16'h0222, 16'h0FFF, 16'h0111};
        neuron_outvalid = 3'b101;
        waitCycles = 0;
        while (!out_valid && waitCycles < 40) begin
            waitCycles++;
            idleCycle();
            neuron_outvalid = 3'b000;
        end
        checkOutput("p2_wait_cycles", waitCycles, 16);
        checkOutput("p2_timeout_err", err, 1);
        checkOutput("p2_beat0_data", out_data, 16'h0111);
        checkOutput("p2_beat0_last", out_last, 0);
        out_ready = 1'b1;
        idleCycle();
        checkOutput("p2_beat1_uncaptured", out_data, 16'h0000);
        idleCycle();
        checkOutput("p2_beat2_data", out_data, 16'h0222);
        checkOutput("p2_beat2_last", out_last, 1);
        idleCycle();
        out_ready = 1'b0;
        checkOutput("p2_done", done, 1);
        checkOutput("p2_err_sticky", err, 1);

        // Reset in the second FEED cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 16'(16'h0040 + k));
        end
        idleCycle();
        checkOutput("p3_feed0_valid", neuron_in_valid, 1);
        idleCycle();
        checkOutput("p3_feed1_data", neuron_in, 16'h0041);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("p3_rst_nin_valid", neuron_in_valid, 0);
        checkOutput("p3_rst_busy", busy, 0);
        checkOutput("p3_rst_cfg_ready", cfg_ready, 1);
        checkOutput("p3_rst_err", err, 0);

        // Start and cfg_valid together: start wins
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd1, 32'h0000_0077, 1'b0, 16'd0);
        checkOutput("p4_cfg_ready", cfg_ready, 0);
        idleCycle();
        checkOutput("p4_no_wstrobe", weightValid, 0);
        checkOutput("p4_no_bstrobe", biasValid, 0);
        checkOutput("p4_weight_kept", weightValue, 0);
        checkOutput("p4_load_in_ready", in_ready, 1);
        checkOutput("p4_busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/fnn_layer_ctrl.md
# fnn_layer_ctrl

Per-layer sequencer for the fully connected network accelerator. It sits between the host/previous-layer stream and one layer's bank of neuron instances. It forwards weight and bias configuration writes to the addressed neuron. It buffers an input vector so the neurons receive it as one gap-free burst, then collects every neuron's activation and streams the results out in neuron order.

## Interface
Parameters:
- LAYER_NO, 2: value driven on config_layer_num.
- NUM_NEURON, 30: neurons in the layer.
- NUM_INPUT, 30: vector length; equals each neuron's numWeight.
- DATA_WIDTH, 16: activation width.
- WAIT_TIMEOUT, 1024: maximum cycles in WAIT before the error path is taken.

Ports:
- Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  high when a configuration write can be accepted
- cfg_is_bias  in  1  1 = bias write, 0 = weight write
- cfg_neuron  in  32  target neuron index
- cfg_data  in  32  weight or bias value
- weightValid, biasValid  out  1  one-cycle write strobes to the neurons
- weightValue, biasValue  out  32  write data
- config_layer_num, config_neuron_num  out  32  neuron address
- start  in  1  begin one inference pass
- in_valid / in_ready  in/out  1  input vector handshake
- in_data  in  DATA_WIDTH  input element
- neuron_in  out  DATA_WIDTH  broadcast input to all neurons (myinput)
- neuron_in_valid  out  1  broadcast valid (myinputValid)
- neuron_out  in  NUM_NEURON*DATA_WIDTH  packed activations; neuron i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- neuron_outvalid  in  NUM_NEURON  per-neuron outvalid
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  DATA_WIDTH  activation of the current neuron index
- out_last  out  1  high on the beat for neuron NUM_NEURON-1
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the last result beat
- err  out  1  sticky error flag; cleared only by rst

## Operation
The controller is a state machine with states IDLE, LOAD, FEED, WAIT and DRAIN.

- **IDLE**
  - cfg_ready = !start.
  - On a cfg handshake, the matching strobe pulses on the next cycle. weightValue or biasValue = cfg_data, config_layer_num = LAYER_NO, config_neuron_num = cfg_neuron.
  - If cfg_neuron >= NUM_NEURON, the write is accepted but no strobe is issued, and err is set.
  - start moves to LOAD. When start and cfg_valid are both high, start wins and the cfg write is not accepted.
- **LOAD**
  - in_ready = 1.
  - Each handshake writes buf[k] and increments k.
  - After NUM_INPUT beats, the state moves to FEED. The capture mask is cleared.
- **FEED**
  - neuron_in_valid is high for exactly NUM_INPUT consecutive cycles, with neuron_in = buf[0..NUM_INPUT-1] in order.
  - After the last element, the state moves to WAIT.
- **WAIT**
  - A cycle counter runs from 0.
  - On any cycle where neuron_outvalid[i] = 1, slot res[i] <= neuron_out slice i and mask[i] is set. Multiple neurons may capture in the same cycle.
  - When the mask is all ones, the state moves to DRAIN.
  - If the counter reaches WAIT_TIMEOUT first, err is set and the state moves to DRAIN. Uncaptured slots output 0.
  - outvalid pulses seen outside WAIT are ignored.
- **DRAIN**
  - out_valid = 1, out_data = res[j], out_last = (j == NUM_NEURON-1).
  - j advances on each handshake. out_data is held stable while out_ready is low.
  - After the last handshake, the state returns to IDLE and done pulses.
- start is ignored outside IDLE.
- cfg_ready is 0 outside IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - cfg_ready = 1; in_ready = 0; out_valid = 0; out_last = 0; out_data = 0.
  - weightValid = 0; biasValid = 0; neuron_in_valid = 0; neuron_in = 0.
  - weightValue, biasValue, config_layer_num and config_neuron_num = 0.
  - busy = 0; done = 0; err = 0; mask = 0.
- A reset mid-pass aborts immediately. Buffer contents are don't-care afterwards.
- Configuration strobe latency is 1 cycle after the handshake. Back-to-back cfg writes are accepted at one per cycle.
- If the last LOAD beat is accepted in cycle L, neuron_in_valid is high in cycles L+1 .. L+NUM_INPUT with no gaps. This gap-free burst is mandatory because each neuron detects completion only on a contiguous valid run.
- The first WAIT cycle is L+NUM_INPUT+1.
- If the final capture occurs in cycle C, out_valid is first high in cycle C+1.
- If the last DRAIN handshake occurs in cycle D, done = 1 in D+1 and busy = 0 from D+1.
- Minimum gap between passes: start is accepted in the cycle done is high.

## Structure
- Package fnn_pkg holds:
  - the state enum (IDLE, LOAD, FEED, WAIT, DRAIN);
  - the cfg word width (32);
  - the function clog2-based index widths.
- Sub-module fnn_vec_buf:
  - NUM_INPUT x DATA_WIDTH register file;
  - one write port and one registered read port;
  - used for the input buffer.
- The result slots and mask are flops inside the controller.

## Test plan
All scenarios use NUM_INPUT = 4, NUM_NEURON = 3, WAIT_TIMEOUT = 16.
- **Config:** cfg writes (weight, neuron 1, 0x00AB) then (bias, neuron 2, 0xFFC0) in consecutive cycles.
  - Required: weightValid pulse with config_neuron_num = 1 and weightValue = 0x00AB, then a biasValid pulse with config_neuron_num = 2. err stays 0.
- **Bad index:** cfg write to neuron 3.
  - Required: no strobe; err = 1 and remains 1 until rst.
- **Stalled load:** start, then inputs 0x0001..0x0004 with in_valid toggled 1,0,1,1,0,1.
  - Required: neuron_in_valid high for 4 consecutive cycles, with neuron_in = 1, 2, 3, 4.
- **Out-of-order capture:** model neurons assert outvalid in order 2, 0 and 1 together (values 0x0030, 0x0010, 0x0020); out_ready held low 2 cycles.
  - Required: out_data sequence 0x0010, 0x0020, 0x0030, held while stalled; out_last on the third beat; done one cycle later.
- **Timeout:** neuron 1 never asserts outvalid.
  - Required: after 16 WAIT cycles err = 1 and DRAIN outputs res0, 0x0000, res2.
- **Reset mid-FEED, start with cfg:**
  - rst in the second FEED cycle: next cycle neuron_in_valid = 0, busy = 0, cfg_ready = 1.
  - start and cfg_valid together: no strobe, and the state moves to LOAD.
